// File: rtl/multicycle_ctrl.sv
// Main control unit for the multicycle processor.
// A Moore FSM walks each instruction through FETCH/DECODE/EXECUTE/WRITEBACK.
// It drives the datapath mux selects and the write requests that go to the
// conditional-logic stage. Op/Funct/Rd come straight from the instruction
// register, which holds them stable for the whole instruction, so nothing
// is latched here.
//
// Control strobes have no valid/ready handshake: every output is meaningful
// in the cycle the state register presents it. The sequencer never stalls,
// and the next state is taken on every rising edge of clk.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_e state_q, state_d;

  logic [3:0] cmd;
  logic       set_flags;
  logic [1:0] dec_alu;
  logic [1:0] dec_flagw;
  logic       dec_nowrite;
  logic       rd_is_pc;

  assign cmd       = Funct[4:1];
  assign set_flags = Funct[0];
  assign rd_is_pc  = (Rd == 4'hF);

  // The state register is visible for debug and checker binding.
  assign dbg_state_o = state_q;

  // Immediate-extension and register-source selects are pure decode of Op.
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

  // State register; reset forces FETCH at once, even mid-instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;  // Op=11 runs as a NOP
        endcase
      end
      S_MEMADR: state_d = set_flags ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // ALU operation, flag enables and compare detection from the cmd field.
  always_comb begin
    dec_alu     = ALU_ADD;
    dec_flagw   = 2'b00;
    dec_nowrite = 1'b0;
    case (cmd)
      4'b0100: begin
        dec_alu   = ALU_ADD;
        dec_flagw = {set_flags, set_flags};
      end
      4'b0010: begin
        dec_alu   = ALU_SUB;
        dec_flagw = {set_flags, set_flags};
      end
      4'b0000: begin
        dec_alu   = ALU_AND;
        dec_flagw = {set_flags, 1'b0};
      end
      4'b1100: begin
        dec_alu   = ALU_ORR;
        dec_flagw = {set_flags, 1'b0};
      end
      4'b1010: begin
        // CMP always updates all flags and never writes a register.
        dec_alu     = ALU_SUB;
        dec_flagw   = 2'b11;
        dec_nowrite = 1'b1;
      end
      default: begin
        dec_alu   = ALU_ADD;
        dec_flagw = 2'b00;
      end
    endcase
  end

  // Moore outputs per state; all strobes and selects read 0 while reset is low.
  always_comb begin
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    NoWrite    = 1'b0;
    FlagW      = 2'b00;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          AdrSrc     = 1'b0;
          IRWrite    = 1'b1;
          NextPC     = 1'b1;
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          ALUControl = ALU_ADD;
        end
        S_DECODE: begin
          // PC+4 computed again so R15 reads as PC+8.
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          ALUControl = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSrcA    = 2'b00;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
        end
        S_MEMRD: begin
          AdrSrc = 1'b1;
        end
        S_MEMWR: begin
          AdrSrc = 1'b1;
          MemW   = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegW      = 1'b1;
          PCS       = rd_is_pc;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b00;
          ALUSrcB    = 2'b00;
          ALUControl = dec_alu;
          FlagW      = dec_flagw;
          NoWrite    = dec_nowrite;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b00;
          ALUSrcB    = 2'b01;
          ALUControl = dec_alu;
          FlagW      = dec_flagw;
          NoWrite    = dec_nowrite;
        end
        S_ALUWB: begin
          // Flags were already written in EXECR/EXECI; only NoWrite persists.
          ResultSrc = 2'b00;
          RegW      = 1'b1;
          NoWrite   = dec_nowrite;
          PCS       = rd_is_pc;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          ResultSrc  = 2'b10;
          PCS        = 1'b1;
        end
        default: begin
          PCS = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table, a mid-instruction
// reset sequence and randomised per-class latency checks.
module tb_multicycle_ctrl;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXECR  = 4'd6;
  localparam logic [3:0] ST_EXECI  = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;

  // Output word: PCS RegW MemW NoWrite FlagW IRWrite NextPC AdrSrc
  //              ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc RegSrc
  localparam logic [20:0] RESET_MASK = 21'h1FFFF0;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] dbg_state_o;

  logic [20:0] outs;
  assign outs = {PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .FlagW      (FlagW),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [24:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [24:0] exp_q[$];
  logic [3:0]  lat_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [24:0] pack_exp(
    input logic [3:0] st, input logic pcs, input logic regw, input logic memw,
    input logic nw, input logic [1:0] fw, input logic irw, input logic npc,
    input logic adr, input logic [1:0] res, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] alu, input logic [1:0] op);
    logic [1:0] regsrc;
    regsrc = {(op == 2'b01), (op == 2'b10)};
    return {st, pcs, regw, memw, nw, fw, irw, npc, adr, res, sa, sb, alu, op, regsrc};
  endfunction

  task automatic add_row(
    input string n, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
    input logic [3:0] st, input logic pcs, input logic regw, input logic memw,
    input logic nw, input logic [1:0] fw, input logic irw, input logic npc,
    input logic adr, input logic [1:0] res, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] alu);
    vec_t v;
    v.name  = n;
    v.op    = op;
    v.funct = f;
    v.rd    = rd;
    v.exp   = pack_exp(st, pcs, regw, memw, nw, fw, irw, npc, adr, res, sa, sb, alu, op);
    vecs.push_back(v);
  endtask

  // FETCH and DECODE rows are the same for every instruction.
  task automatic add_fd(input string n, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd);
    add_row({n, ".fetch"}, op, f, rd, ST_FETCH, 0, 0, 0, 0, 2'b00, 1, 1, 0,
            2'b10, 2'b01, 2'b10, 2'b00);
    add_row({n, ".decode"}, op, f, rd, ST_DECODE, 0, 0, 0, 0, 2'b00, 0, 0, 0,
            2'b10, 2'b01, 2'b10, 2'b00);
  endtask

  // Scoreboard: pop the oldest expectation and compare state and outputs.
  task automatic check_pop(input string n);
    logic [24:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", n);
    end else begin
      e = exp_q.pop_front();
      n_checks += 2;
      if (dbg_state_o !== e[24:21]) begin
        n_fail++;
        $display("FAIL %s state: got %0d, expected %0d", n, dbg_state_o, e[24:21]);
      end
      if (outs !== e[20:0]) begin
        n_fail++;
        $display("FAIL %s outputs: got %b, expected %b", n, outs, e[20:0]);
      end
    end
  endtask

  task automatic check_reset(input string n);
    n_checks += 2;
    if (dbg_state_o !== ST_FETCH) begin
      n_fail++;
      $display("FAIL %s state: got %0d, expected 0", n, dbg_state_o);
    end
    if ((outs & RESET_MASK) !== 21'd0) begin
      n_fail++;
      $display("FAIL %s outputs: got %b, expected all strobes 0", n, outs & RESET_MASK);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    Op    = op;
    Funct = f;
    Rd    = rd;
  endtask

  initial begin
    int          cycles;
    logic [1:0]  rop;
    logic [5:0]  rf;
    logic [3:0]  exp_lat;
    logic [3:0]  got_lat;

    // Vector table: {inputs, expected state and outputs} per cycle.
    add_fd("add_s", 2'b00, 6'b001001, 4'd1);
    add_row("add_s.execr", 2'b00, 6'b001001, 4'd1, ST_EXECR, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_row("add_s.aluwb", 2'b00, 6'b001001, 4'd1, ST_ALUWB, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("cmp_i", 2'b00, 6'b110101, 4'd0);
    add_row("cmp_i.execi", 2'b00, 6'b110101, 4'd0, ST_EXECI, 0, 0, 0, 1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01);
    add_row("cmp_i.aluwb", 2'b00, 6'b110101, 4'd0, ST_ALUWB, 0, 1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("ldr_pc", 2'b01, 6'b011001, 4'hF);
    add_row("ldr_pc.memadr", 2'b01, 6'b011001, 4'hF, ST_MEMADR, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    add_row("ldr_pc.memrd", 2'b01, 6'b011001, 4'hF, ST_MEMRD, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add_row("ldr_pc.memwb", 2'b01, 6'b011001, 4'hF, ST_MEMWB, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add_fd("str", 2'b01, 6'b011000, 4'd2);
    add_row("str.memadr", 2'b01, 6'b011000, 4'd2, ST_MEMADR, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    add_row("str.memwr", 2'b01, 6'b011000, 4'd2, ST_MEMWR, 0, 0, 1, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("b", 2'b10, 6'b100000, 4'd0);
    add_row("b.branch", 2'b10, 6'b100000, 4'd0, ST_BRANCH, 1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00);
    add_fd("orr", 2'b00, 6'b011000, 4'd3);
    add_row("orr.execr", 2'b00, 6'b011000, 4'd3, ST_EXECR, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11);
    add_row("orr.aluwb", 2'b00, 6'b011000, 4'd3, ST_ALUWB, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("nop11", 2'b11, 6'b000000, 4'd0);
    add_fd("sub_pc", 2'b00, 6'b000101, 4'hF);
    add_row("sub_pc.execr", 2'b00, 6'b000101, 4'hF, ST_EXECR, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01);
    add_row("sub_pc.aluwb", 2'b00, 6'b000101, 4'hF, ST_ALUWB, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("and_i", 2'b00, 6'b100001, 4'd5);
    add_row("and_i.execi", 2'b00, 6'b100001, 4'd5, ST_EXECI, 0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10);
    add_row("and_i.aluwb", 2'b00, 6'b100001, 4'd5, ST_ALUWB, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_fd("eor", 2'b00, 6'b000011, 4'd6);
    add_row("eor.execr", 2'b00, 6'b000011, 4'd6, ST_EXECR, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add_row("eor.aluwb", 2'b00, 6'b000011, 4'd6, ST_ALUWB, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset phase.
    reset = 1'b0;
    drive(2'b00, 6'b000000, 4'd0);
    repeat (2) @(negedge clk);
    #1 check_reset("por");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven run: one vector per clock cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].rd);
      exp_q.push_back(vecs[i].exp);
      #1 check_pop(vecs[i].name);
      @(negedge clk);
    end

    // LDR interrupted by reset while in MEMRD.
    drive(2'b01, 6'b000001, 4'd4);
    repeat (3) @(negedge clk);
    exp_q.push_back(pack_exp(ST_MEMRD, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    #1 check_pop("midrst.memrd");
    #1 reset = 1'b0;
    #1 check_reset("midrst.async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_reset("midrst.held");
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(pack_exp(ST_FETCH, 0, 0, 0, 0, 2'b00, 1, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01));
    #1 check_pop("midrst.fetch");
    @(negedge clk);
    exp_q.push_back(pack_exp(ST_DECODE, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01));
    #1 check_pop("midrst.decode");
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (dbg_state_o !== ST_FETCH && cycles < 12);
    n_checks++;
    if (cycles != 4) begin
      n_fail++;
      $display("FAIL midrst.finish: returned to FETCH after %0d cycles, expected 4", cycles);
    end

    // Random instructions: cycles from FETCH to the next FETCH per class.
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      drive(rop, rf, 4'($urandom_range(0, 15)));
      case (rop)
        2'b11:   exp_lat = 4'd2;
        2'b10:   exp_lat = 4'd3;
        2'b00:   exp_lat = 4'd4;
        default: exp_lat = rf[0] ? 4'd5 : 4'd4;
      endcase
      lat_q.push_back(exp_lat);
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
      end while (dbg_state_o !== ST_FETCH && cycles < 12);
      got_lat = 4'(cycles);
      exp_lat = lat_q.pop_front();
      n_checks++;
      if (got_lat !== exp_lat) begin
        n_fail++;
        $display("FAIL latency op=%b funct=%b: got %0d cycles, expected %0d", rop, rf, got_lat, exp_lat);
      end
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle version of the processor. It decodes instruction fields from the instruction register and sequences FETCH/DECODE/EXECUTE/WRITEBACK through a Moore state machine.
- It sits directly upstream of the conditional-logic stage and drives its PCS, RegW, MemW, FlagW and NoWrite inputs.
- It also drives datapath mux selects, IRWrite and the unconditional NextPC request.

Parameters:
- RESET_STATE, 4'd0, state encoding entered on reset (FETCH); must match the FETCH encoding.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; 0 forces FETCH immediately.
- Op  input  2  instruction class, Instr[27:26].
- Funct  input  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S.
- Rd  input  4  destination register, Instr[15:12].
- PCS  output  1  PC-writing request to conditional logic.
- RegW  output  1  register-write request (conditionally gated downstream).
- MemW  output  1  memory-write request (conditionally gated downstream).
- NoWrite  output  1  suppress register write (CMP).
- FlagW  output  2  flag-write enables: [1]=NZ, [0]=CV.
- IRWrite  output  1  instruction-register load.
- NextPC  output  1  unconditional PC update.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result.
- ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  output  2  ALU operand A select: 00=RD1, 01=PC, 10=ALUOut.
- ALUSrcB  output  2  ALU operand B select: 00=RD2, 01=ExtImm, 10=const 4.
- ALUControl  output  2  ALU operation: 00=ADD, 01=SUB, 10=AND, 11=ORR.
- ImmSrc  output  2  equals Op.
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01).

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- State register updates on the rising edge of clk.
- Asynchronous clear on reset low, including mid-instruction: state=FETCH and every registered output is 0. Outputs then read FETCH values once reset is high.
- Outputs are a Moore function of the state only; ALUControl, FlagW and NoWrite additionally depend on Funct. Any output not listed for a state is 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH (treated as NOP, no side effects).
  - MEMADR: Funct[0]=1->MEMRD, else->MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD (PC+8 appears on R15 read).
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALU decode active.
  - EXECI: ALUSrcA=00, ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegW=1, NoWrite held from decode.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCS=1.
- ALU decode (EXECR/EXECI only), by cmd:
  - 0100=ADD.
  - 0010=SUB.
  - 0000=AND.
  - 1100=ORR.
  - 1010=CMP: ALUControl=SUB, NoWrite=1, FlagW=11 regardless of S.
  - Any other cmd: ADD, FlagW=00.
- Flag writes:
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD or SUB).
  - FlagW is nonzero only in EXECR/EXECI, so flags update exactly once per instruction.
- PCS in writeback states: MEMWB and ALUWB assert PCS=(Rd==4'hF).
- NoWrite is valid in EXECR/EXECI/ALUWB and 0 elsewhere.
- Latency: branch 3 cycles, data-processing 4, STR 4, LDR 5, Op=11 2 (cycles from FETCH to the next FETCH).
- Op/Funct/Rd are sampled from the instruction register, which is stable after FETCH; the block does not latch them.

Test Plan:
- reset=0 for 2 cycles mid-LDR (state MEMRD) -> state=FETCH immediately (async); after release IRWrite=1, NextPC=1, AdrSrc=0 on the first cycle.
- ADD R1,R2,R3 with S=1 (Op=00, Funct=6'b001001, Rd=1) -> FETCH, DECODE, EXECR (ALUControl=00, FlagW=11), ALUWB (RegW=1, PCS=0) -> FETCH.
- CMP imm (Op=00, Funct=6'b110101) -> EXECI with ALUSrcB=01, ALUControl=01, FlagW=11, NoWrite=1; ALUWB has NoWrite=1.
- LDR PC (Op=01, Funct[0]=1, Rd=15) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1, PCS=1); 5 cycles total.
- STR (Op=01, Funct[0]=0) -> MEMWR with MemW=1, AdrSrc=1, RegW=0 -> FETCH; B (Op=10) -> BRANCH with PCS=1, ALUSrcA=10.
- ORR without S (Funct=6'b011000) -> FlagW=00 in all states; Op=11 -> DECODE->FETCH with no write strobes asserted.
